// File: rtl/mul_div_unit.sv
// mul_div_unit -- 8-bit iterative multiply / divide unit.
//
// Multiply uses shift-add and divide uses restoring shift-subtract. Each
// handles one operand bit per RUN cycle over 8 cycles, so done follows an
// accepted start by 9 cycles. Divide by zero skips RUN, so done follows
// start by 1 cycle.
//
// Optional feature: define MUL_DIV_SIGNED_EN to enable signed MULS/DIVS
// (op 10/11). Without it, op[1] is ignored and only unsigned
// arithmetic is built.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request an operation (sampled only in IDLE)
//   op         00 MULU, 01 DIVU, 10 MULS, 11 DIVS
//   dataA      multiplicand / dividend
//   dataB      multiplier / divisor
//   busy       high whenever state is not IDLE
//   done       one-cycle pulse with a valid result
//   result_hi  product[15:8] / remainder
//   result_lo  product[7:0]  / quotient
//   cout       carry: product overflows 8 bits, divide by zero, DIVS overflow
//   zout       zero: product == 0 / quotient == 0
//   nout       negative: product[15] / quotient[7]
module mul_div_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] dataA,
  input  logic [7:0] dataB,
  output logic       busy,
  output logic       done,
  output logic [7:0] result_hi,
  output logic [7:0] result_lo,
  output logic       cout,
  output logic       zout,
  output logic       nout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        is_div;
  logic [7:0]  m_reg;   // multiplicand (mul) or divisor (div) magnitude
  logic [15:0] work;    // mul: {partial sum, multiplier}; div: {remainder, quotient}

  logic [7:0]  mag_a, mag_b;

`ifdef MUL_DIV_SIGNED_EN
  logic is_sgn, neg_main, neg_rem, ovf;
  logic sgn_req;

  assign sgn_req = op[1];

  // The core works on magnitudes. 0x80 maps to 128, which is correct as unsigned.
  always_comb begin
    mag_a = (sgn_req && dataA[7]) ? 8'(-dataA) : dataA;
    mag_b = (sgn_req && dataB[7]) ? 8'(-dataB) : dataB;
  end
`else
  logic unused_op1;

  assign unused_op1 = op[1];

  always_comb begin
    mag_a = dataA;
    mag_b = dataB;
  end
`endif

  // One iteration step.
  logic [8:0]  add_s;
  logic [8:0]  shl;
  logic [15:0] work_nx;

  always_comb begin
    add_s   = '0;
    shl     = '0;
    work_nx = work;
    if (is_div) begin
      shl = {work[15:8], work[7]};
      if (shl >= {1'b0, m_reg})
        work_nx = {8'(shl - {1'b0, m_reg}), work[6:0], 1'b1};
      else
        work_nx = {shl[7:0], work[6:0], 1'b0};
    end else begin
      add_s   = {1'b0, work[15:8]} + (work[0] ? {1'b0, m_reg} : 9'd0);
      work_nx = {add_s, work[7:1]};
    end
  end

  // Final result and flags, captured on the last RUN cycle.
  logic [7:0]  fin_hi, fin_lo;
  logic        fin_c, fin_z, fin_n;

  always_comb begin
    fin_hi = work_nx[15:8];
    fin_lo = work_nx[7:0];
    fin_c  = 1'b0;
`ifdef MUL_DIV_SIGNED_EN
    if (is_div) begin
      if (neg_main) fin_lo = 8'(-work_nx[7:0]);
      if (neg_rem)  fin_hi = 8'(-work_nx[15:8]);
      fin_c = ovf;
    end else begin
      if (neg_main) {fin_hi, fin_lo} = 16'(-work_nx);
      if (is_sgn)
        fin_c = (fin_hi != {8{fin_lo[7]}});
      else
        fin_c = (fin_hi != '0);
    end
`else
    fin_c = !is_div && (fin_hi != '0);
`endif
    if (is_div) begin
      fin_z = (fin_lo == '0);
      fin_n = fin_lo[7];
    end else begin
      fin_z = ({fin_hi, fin_lo} == '0);
      fin_n = fin_hi[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      m_reg     <= '0;
      work      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      cout      <= 1'b0;
      zout      <= 1'b0;
      nout      <= 1'b0;
`ifdef MUL_DIV_SIGNED_EN
      is_sgn    <= 1'b0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[0];
            cnt    <= '0;
            busy   <= 1'b1;
            if (op[0] && dataB == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              result_lo <= '1;
              result_hi <= dataA;
              cout      <= 1'b1;
              zout      <= 1'b0;
              nout      <= 1'b1;
            end else begin
              state <= RUN;
              m_reg <= op[0] ? mag_b : mag_a;
              work  <= {8'h00, (op[0] ? mag_a : mag_b)};
            end
`ifdef MUL_DIV_SIGNED_EN
            is_sgn   <= sgn_req;
            neg_main <= sgn_req && (dataA[7] ^ dataB[7]);
            neg_rem  <= sgn_req && dataA[7];
            ovf      <= sgn_req && op[0] && (dataA == 8'h80) && (dataB == 8'hFF);
`endif
          end
        end
        RUN: begin
          work <= work_nx;
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state     <= DONE;
            done      <= 1'b1;
            result_hi <= fin_hi;
            result_lo <= fin_lo;
            cout      <= fin_c;
            zout      <= fin_z;
            nout      <= fin_n;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = '0;
  logic [7:0] dataA = '0;
  logic [7:0] dataB = '0;
  logic       busy, done, cout, zout, nout;
  logic [7:0] result_hi, result_lo;

  int n_cmp = 0;
  int n_fail = 0;

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
    .result_hi(result_hi), .result_lo(result_lo),
    .cout(cout), .zout(zout), .nout(nout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a, b;
    logic [7:0] hi, lo;
    logic       c, z, n;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    start = 1'b1; op = v.op; dataA = v.a; dataB = v.b;
    @(negedge clk);
    // After acceptance the operand inputs must not matter.
    start = 1'b0; op = 2'b00; dataA = 8'h5A; dataB = 8'hA5;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", idx), 16'(lat), 16'(v.lat));
    chk($sformatf("v%0d result", idx), {result_hi, result_lo}, {v.hi, v.lo});
    chk($sformatf("v%0d flags czn", idx), {13'd0, cout, zout, nout}, {13'd0, v.c, v.z, v.n});
    @(negedge clk);
    chk($sformatf("v%0d busy/done after", idx), {14'd0, busy, done}, 16'd0);
    chk($sformatf("v%0d result held", idx), {result_hi, result_lo}, {v.hi, v.lo});
  endtask

  initial begin
    int dones, dcyc;
    logic busy5, busy10;
    vec_t v;

    //                op     a      b      hi     lo     c     z     n    lat
    vecs.push_back('{2'b00, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b1, 1'b0, 1'b1, 9});
    vecs.push_back('{2'b01, 8'hC8, 8'h07, 8'h04, 8'h1C, 1'b0, 1'b0, 1'b0, 9});
    vecs.push_back('{2'b01, 8'h05, 8'h00, 8'h05, 8'hFF, 1'b1, 1'b0, 1'b1, 1});
    vecs.push_back('{2'b00, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 9});
    vecs.push_back('{2'b00, 8'h10, 8'h10, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 9});
    vecs.push_back('{2'b01, 8'h03, 8'h07, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0, 9});
    vecs.push_back('{2'b00, 8'h0F, 8'h0F, 8'h00, 8'hE1, 1'b0, 1'b0, 1'b0, 9});
    vecs.push_back('{2'b01, 8'hFF, 8'h01, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 9});
`ifdef MUL_DIV_SIGNED_EN
    vecs.push_back('{2'b11, 8'hF9, 8'h02, 8'hFF, 8'hFD, 1'b0, 1'b0, 1'b1, 9});
    vecs.push_back('{2'b10, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 9});
    vecs.push_back('{2'b11, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1, 9});
    vecs.push_back('{2'b10, 8'hFE, 8'h03, 8'hFF, 8'hFA, 1'b0, 1'b0, 1'b1, 9});
    vecs.push_back('{2'b11, 8'h07, 8'hFE, 8'h01, 8'hFD, 1'b0, 1'b0, 1'b1, 9});
`else
    vecs.push_back('{2'b11, 8'hF9, 8'h02, 8'h01, 8'h7C, 1'b0, 1'b0, 1'b0, 9});
    vecs.push_back('{2'b10, 8'h80, 8'hFF, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 9});
    vecs.push_back('{2'b11, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 9});
    vecs.push_back('{2'b10, 8'hFE, 8'h03, 8'h02, 8'hFA, 1'b1, 1'b0, 1'b0, 9});
    vecs.push_back('{2'b11, 8'h07, 8'hFE, 8'h07, 8'h00, 1'b0, 1'b1, 1'b0, 9});
`endif
    vecs.push_back('{2'b11, 8'h09, 8'h00, 8'h09, 8'hFF, 1'b1, 1'b0, 1'b1, 1});

    // Outputs are zero while reset is held.
    #12;
    chk("reset outputs", {3'd0, busy, done, cout, zout, nout, result_hi},
        {11'd0, 5'd0});
    chk("reset result_lo", {8'd0, result_lo}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // A second start pulse during RUN must not disturb MULU 3*4.
    @(negedge clk);
    start = 1'b1; op = 2'b00; dataA = 8'h03; dataB = 8'h04;
    dones = 0; dcyc = 0; busy5 = 1'b0; busy10 = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      start = (cyc == 3);
      if (cyc == 3) begin op = 2'b01; dataA = 8'hFF; dataB = 8'h00; end
      if (done) begin dones++; dcyc = cyc; end
      if (cyc == 5) busy5 = busy;
      if (cyc == 10) busy10 = busy;
    end
    chk("restart done count", 16'(dones), 16'd1);
    chk("restart done cycle", 16'(dcyc), 16'd9);
    chk("restart busy in RUN", {15'd0, busy5}, 16'd1);
    chk("restart busy after", {15'd0, busy10}, 16'd0);
    chk("restart result", {result_hi, result_lo}, 16'h000C);
    chk("restart flags czn", {13'd0, cout, zout, nout}, 16'd0);

    // Reset in the 4th RUN cycle aborts the operation immediately.
    @(negedge clk);
    start = 1'b1; op = 2'b00; dataA = 8'hFF; dataB = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy/done/flags", {11'd0, busy, done, cout, zout, nout}, 16'd0);
    chk("abort result", {result_hi, result_lo}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort no done", 16'(dones), 16'd0);
    chk("abort idle", {15'd0, busy}, 16'd0);
    v = '{2'b01, 8'h09, 8'h03, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 9};
    run_vec(v, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
